// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MD_DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring shift-subtract divide step on unsigned magnitudes.
// Latency: combinational; the owning FSM registers the result once per cycle.
// Backpressure: none, pure function of its inputs.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quot
);

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    assign w_shift = {i_rem, i_quot[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign w_neg   = w_diff[WIDTH+1];

    // Restore on borrow, otherwise keep the difference; quotient bit is the inverted borrow.
    always_comb begin
        o_rem  = w_neg ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
        o_quot = {i_quot[WIDTH-2:0], ~w_neg};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural HI/LO registers.
// Latency: MT writes at acceptance edge; MUL Done at cycle MUL_STAGES+1; DIV Done at WIDTH+2; div-by-zero Done at 2.
// Backpressure: Busy high while working; StartE during Busy is dropped, Cancel aborts without writing HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = MD_DEFAULT_WIDTH,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_prod [MUL_STAGES];
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_done;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_sgn_mul;
    logic             w_sgn_div;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;
    logic             w_mul_done;
    logic             w_fix_done;

    assign w_accept  = StartE && !Cancel && (r_state == S_IDLE);
    assign w_is_mul  = (OpE == OP_MULT) || (OpE == OP_MULTU);
    assign w_is_div  = (OpE == OP_DIV)  || (OpE == OP_DIVU);
    assign w_b_zero  = (SrcBE == '0);
    assign w_sgn_mul = (OpE == OP_MULT);
    assign w_sgn_div = (OpE == OP_DIV);

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign w_a_ext = {{WIDTH{w_sgn_mul & SrcAE[WIDTH-1]}}, SrcAE};
    assign w_b_ext = {{WIDTH{w_sgn_mul & SrcBE[WIDTH-1]}}, SrcBE};
    assign w_prod  = w_a_ext * w_b_ext;

    // MIN negates to itself, which is exactly its unsigned magnitude.
    assign w_a_mag = (w_sgn_div && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign w_b_mag = (w_sgn_div && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_quot (r_quot),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_quot (w_quot_nxt)
    );

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; Cancel returns any working state to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul)      w_next = S_MUL;
                    else if (w_is_div) w_next = w_b_zero ? S_FIX : S_DIV;
                end
            end
            S_MUL:   w_next = (Cancel || r_cnt == '0) ? S_IDLE : S_MUL;
            S_DIV:   w_next = Cancel ? S_IDLE : ((r_cnt == '0) ? S_FIX : S_DIV);
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state: Busy plus the result-commit strobes.
    always_comb begin
        Busy       = (r_state != S_IDLE);
        w_mul_done = (r_state == S_MUL) && (r_cnt == '0) && !Cancel;
        w_fix_done = (r_state == S_FIX) && !Cancel;
    end

    // Datapath: operand capture, multiply delay line, divide iteration and HI/LO commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            for (int i = 0; i < MUL_STAGES; i++) r_prod[i] <= '0;
        end else begin
            r_done    <= w_mul_done || w_fix_done;
            r_divzero <= w_fix_done && r_dz;

            // Product travels one stage per cycle; the last stage is ready when the counter hits 0.
            for (int i = 1; i < MUL_STAGES; i++) r_prod[i] <= r_prod[i-1];

            if (w_accept) begin
                if (OpE == OP_MTHI) r_hi <= SrcAE;
                if (OpE == OP_MTLO) r_lo <= SrcAE;
                if (w_is_mul) begin
                    r_prod[0] <= w_prod;
                    r_cnt     <= CW'(MUL_STAGES - 1);
                end
                if (w_is_div) begin
                    r_rem   <= '0;
                    r_quot  <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_neg_q <= w_sgn_div && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                    r_neg_r <= w_sgn_div && SrcAE[WIDTH-1];
                    r_dz    <= w_b_zero;
                    r_cnt   <= CW'(WIDTH - 1);
                end
            end

            if (r_state == S_MUL && r_cnt != '0) r_cnt <= r_cnt - CW'(1);

            if (r_state == S_DIV) begin
                r_rem  <= w_rem_nxt;
                r_quot <= w_quot_nxt;
                if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end

            if (w_mul_done) {r_hi, r_lo} <= r_prod[MUL_STAGES-1];

            // Sign fix-up on the magnitudes: quotient toward zero, remainder follows dividend.
            if (w_fix_done && !r_dz) begin
                r_lo <= r_neg_q ? -r_quot : r_quot;
                r_hi <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            end
        end
    end

    assign Done    = r_done;
    assign DivZero = r_divzero;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit at default parameters.
// Latency: measures Done cycle relative to the acceptance cycle.
// Backpressure: exercises ignored starts, Cancel and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        StartE;
    logic [2:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        Cancel;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .StartE  (StartE),
        .OpE     (OpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .Cancel  (Cancel),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents an op in cycle 0 and returns #1 after the acceptance edge (start of cycle 1).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
        @(posedge clk); #1;
        StartE = 1'b0; SrcAE = 32'hA5A5A5A5; SrcBE = 32'h5A5A5A5A;
    endtask

    // Returns at the falling edge of the Done cycle; lat=0 if Done never arrives.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (Done) begin
                lat = c;
                if (Busy) busy_ok = 1'b0;
                break;
            end
            if (!Busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   lat;
        logic bok;
        start_op(v.op, v.a, v.b);
        wait_done(lat, bok);
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_busy"},    {31'd0, bok}, 32'd1);
        chk({tag, "_hi"},      HI, v.hi);
        chk({tag, "_lo"},      LO, v.lo);
        chk({tag, "_divzero"}, {31'd0, DivZero}, {31'd0, v.dz});
    endtask

    initial begin
        int   lat;
        logic bok;
        logic saw_done;

        rst = 1'b1; StartE = 1'b0; OpE = 3'b111; SrcAE = '0; SrcBE = '0; Cancel = 1'b0;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 3};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[5] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 2};
        vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3};
        vecs[8] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 3};
        vecs[9] = '{OP_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 34};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",    {31'd0, Busy},    32'd0);
        chk("rst_done",    {31'd0, Done},    32'd0);
        chk("rst_divzero", {31'd0, DivZero}, 32'd0);
        chk("rst_hi",      HI, 32'd0);
        chk("rst_lo",      LO, 32'd0);

        // Table of single operations, each with a hand-computed result
        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // MTLO issued in the Done cycle of a MULTU
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bok);
        chk("b2b_mul_latency", 32'(lat), 32'd3);
        chk("b2b_mul_lo", LO, 32'h00000001);
        StartE = 1'b1; OpE = OP_MTLO; SrcAE = 32'h12345678;
        @(posedge clk); #1;
        StartE = 1'b0;
        @(negedge clk);
        chk("b2b_done_pulse", {31'd0, Done}, 32'd0);
        chk("b2b_mt_busy",    {31'd0, Busy}, 32'd0);
        chk("b2b_mtlo_lo",    LO, 32'h12345678);
        chk("b2b_mtlo_hi",    HI, 32'hFFFFFFFE);

        // DIV with a MULT held on StartE while busy, then Cancel in cycle 10
        start_op(OP_DIV, 32'd100, 32'd7);
        bok = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            StartE = 1'b1; OpE = OP_MULT; SrcAE = 32'd3; SrcBE = 32'd3;
            @(negedge clk);
            if (!Busy) bok = 1'b0;
            @(posedge clk); #1;
        end
        Cancel = 1'b1;
        @(negedge clk);
        if (!Busy) bok = 1'b0;
        @(posedge clk); #1;
        Cancel = 1'b0; StartE = 1'b0;
        @(negedge clk);
        chk("cancel_busy_before", {31'd0, bok}, 32'd1);
        chk("cancel_busy_after",  {31'd0, Busy}, 32'd0);
        saw_done = Done;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Done) saw_done = 1'b1;
        end
        chk("cancel_no_done", {31'd0, saw_done}, 32'd0);
        chk("cancel_hi", HI, 32'hFFFFFFFE);
        chk("cancel_lo", LO, 32'h12345678);

        // Cancel together with StartE in IDLE drops the MTHI
        @(posedge clk); #1;
        StartE = 1'b1; OpE = OP_MTHI; SrcAE = 32'hDEADBEEF; Cancel = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0; Cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_hi", HI, 32'hFFFFFFFE);

        // Reserved op code is a no-op
        @(posedge clk); #1;
        StartE = 1'b1; OpE = 3'b110; SrcAE = 32'h11111111; SrcBE = 32'h22222222;
        @(posedge clk); #1;
        StartE = 1'b0;
        @(negedge clk);
        chk("noop_busy", {31'd0, Busy}, 32'd0);
        chk("noop_hi",   HI, 32'hFFFFFFFE);
        chk("noop_lo",   LO, 32'h12345678);

        // Reset asserted in cycle 5 of a DIV
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_hi",   HI, 32'd0);
        chk("midrst_lo",   LO, 32'd0);
        saw_done = Done;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);

        // Unit is usable again after the reset
        run_vec("post_rst", '{OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 34});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, attached beside the ALU in the EX stage of the 5-stage pipeline. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO over multiple cycles behind a start/busy/done handshake. The hazard unit stalls on `Busy` and squashes an in-flight operation with `Cancel`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; even, ≥ 4.
- `MUL_STAGES`, 2: multiply latency in busy cycles; ≥ 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `StartE`  in  1  issue request; accepted only in a cycle with `Busy`=0.
- `OpE`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `SrcAE`  in  WIDTH  multiplicand / dividend / MT source.
- `SrcBE`  in  WIDTH  multiplier / divisor.
- `Cancel`  in  1  abort the in-flight operation; HI/LO keep their old values.
- `Busy`  out  1  operation in progress.
- `Done`  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- `DivZero`  out  1  valid with `Done`; set when the divisor was 0.
- `HI`, `LO`  out  WIDTH  architectural registers.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Acceptance is on the edge closing a cycle with `StartE`=1, `Busy`=0, `Cancel`=0. Operands and op are latched at that edge. `SrcAE`/`SrcBE` are don't-care afterwards.
- MTHI/MTLO: HI (or LO) ← `SrcAE` at the acceptance edge. State stays IDLE; no `Busy`, no `Done`.
- MULT/MULTU: IDLE→MUL, with a counter of MUL_STAGES cycles. On exit: {HI,LO} ← full 2·WIDTH product, signed for MULT and unsigned for MULTU. `Done`=1 and the state returns to IDLE.
- DIV/DIVU with divisor ≠ 0: IDLE→DIV.
  - Latch |A| and |B| (raw values for DIVU) plus the result signs.
  - WIDTH restoring shift-subtract iterations, one per cycle.
  - DIV→FIX: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - At the FIX exit edge: LO ← quotient, HI ← remainder. `Done`=1, state → IDLE.
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Overflow case MIN/−1 gives LO=MIN, HI=0. This follows from unsigned-magnitude arithmetic with no special case.
- Divisor = 0: IDLE→FIX for one cycle, then `Done`=1 and `DivZero`=1. HI/LO are unchanged.
- `DivZero` is 0 on every other `Done`.
- `StartE` while `Busy`=1: ignored, with no queuing. The hazard unit must hold the instruction in EX.
- `Cancel`=1 in any non-IDLE state: next state is IDLE, with no `Done` and no HI/LO write.
- `Cancel` together with `StartE` in IDLE: the start is dropped.
- `Cancel` in the cycle HI/LO would be written: the cancel wins and there is no write.
- Reset takes priority over everything, including a reset mid-operation. Result: IDLE, HI=LO=0, `Busy`=`Done`=`DivZero`=0, counters 0.
- Internal counter width is clog2(WIDTH+1). The divide remainder register is WIDTH+1 bits wide so the subtract borrow is kept.

## Timing
- Cycle 0 is the acceptance cycle, and `Busy` is still 0 in cycle 0.
- `Busy`=1 for every state other than IDLE. `Done` is registered and asserted in the first IDLE cycle after MUL/FIX.
- MULT/MULTU: `Busy` in cycles 1..MUL_STAGES; `Done` in cycle MUL_STAGES+1 (3 by default).
- DIV/DIVU: `Busy` in cycles 1..WIDTH+1; `Done` in cycle WIDTH+2 (34 by default).
- Divide by zero: `Busy` in cycle 1; `Done` in cycle 2.
- Back-to-back issue: a new `StartE` is accepted in the `Done` cycle.
- An MT write in the `Done` cycle takes effect at the following edge.
- `HI`/`LO` are direct register outputs with no combinational path from the inputs.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (`OP_MULT`…`OP_MTLO`);
  - the state enum (`S_IDLE`, `S_MUL`, `S_DIV`, `S_FIX`);
  - a default-width constant.
- Sub-module `muldiv_div_step`: the combinational single restoring step, taking (rem, quot, divisor) and producing the next (rem, quot). It is instantiated once and iterated by the FSM.
- The multiplier is a plain registered product followed by a MUL_STAGES−1 deep delay, so the tool can retime it.

## Test plan
- MULT with A=FFFFFFFD (−3), B=5 → `Done` in cycle 3, HI=FFFFFFFF, LO=FFFFFFF1, `DivZero`=0.
- MULTU with A=B=FFFFFFFF → HI=FFFFFFFE, LO=00000001. A MTLO of 12345678 issued in the `Done` cycle then gives LO=12345678, HI unchanged.
- DIV with A=FFFFFFF9 (−7), B=2 → `Done` in cycle 34, LO=FFFFFFFD, HI=FFFFFFFF. DIVU with A=7, B=2 → LO=3, HI=1.
- DIV with A=80000000, B=FFFFFFFF → LO=80000000, HI=00000000. DIVU with A=7, B=0 → `Done` in cycle 2, `DivZero`=1, HI/LO unchanged.
- Cancel and ignored start: issue DIV, hold `StartE`=1 with a MULT during `Busy` (ignored), then `Cancel` in cycle 10. Expect `Busy`=0 in cycle 11, no `Done` pulse, HI/LO unchanged.
- Reset: assert `rst` in cycle 5 of a DIV → next cycle has `Busy`=0, HI=LO=0, and no `Done` follows.
